// File: rtl/mem_data_arbiter_if.sv
// Bus bundle between the two requesters (load/store unit, debug/DMA), the
// arbiter and the single-ported data memory.
interface mem_data_arbiter_if #(
  parameter int XLEN       = 32,
  parameter int ADDRESSLEN = 32
);
  logic                  m0_req;
  logic                  m1_req;
  logic                  m0_we;
  logic                  m1_we;
  logic [ADDRESSLEN-1:0] m0_addr;
  logic [ADDRESSLEN-1:0] m1_addr;
  logic [XLEN-1:0]       m0_wdata;
  logic [XLEN-1:0]       m1_wdata;
  logic                  m0_gnt;
  logic                  m1_gnt;
  logic                  m0_rvalid;
  logic                  m1_rvalid;
  logic [XLEN-1:0]       m0_rdata;
  logic [XLEN-1:0]       m1_rdata;
  logic                  m0_err;
  logic                  m1_err;
  logic [ADDRESSLEN-1:0] mem_write_address;
  logic [ADDRESSLEN-1:0] mem_read_address;
  logic [XLEN-1:0]       mem_data;
  logic                  mem_write_en;
  logic                  mem_read_en;
  logic [XLEN-1:0]       mem_out;

  // Requesters plus memory model.
  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output mem_out,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, m0_err, m1_err,
    input  mem_write_address, mem_read_address, mem_data, mem_write_en, mem_read_en
  );

  // Arbiter side.
  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  mem_out,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, m0_err, m1_err,
    output mem_write_address, mem_read_address, mem_data, mem_write_en, mem_read_en
  );
endinterface

// File: rtl/mem_data_arbiter.sv
// Two-requester round-robin arbiter in front of a single data memory port.
// Optional macro MEM_DATA_ARBITER_ALIGN_CHECK_EN rejects non-word-aligned accesses.
module mem_data_arbiter #(
  parameter int XLEN       = 32,
  parameter int ADDRESSLEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_data_arbiter_if.slave   bus,
  output logic [1:0]          dbg_state
);

  // Handshake: a requester holds req, we, addr and wdata until it sees its
  // one-cycle gnt. Operands are sampled only in IDLE, so dropping req after
  // capture is harmless. A read's rvalid/rdata pulse follows gnt by one cycle;
  // writes and rejected (err) accesses complete with gnt alone.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]            state;
  logic                  last_grant;
  logic                  win;
  logic                  we_q;
  logic [ADDRESSLEN-1:0] addr_q;
  logic [XLEN-1:0]       wdata_q;
  logic [XLEN-1:0]       rdata0_q;
  logic [XLEN-1:0]       rdata1_q;
  logic                  pick;
  logic                  misaligned;
  logic                  issue;
  logic                  resp;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    pick = bus.m1_req;
    if (bus.m0_req && bus.m1_req) pick = ~last_grant;
  end

`ifdef MEM_DATA_ARBITER_ALIGN_CHECK_EN
  assign misaligned = (addr_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      win        <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.m0_req || bus.m1_req) begin
            win        <= pick;
            last_grant <= pick;
            we_q       <= pick ? bus.m1_we    : bus.m0_we;
            addr_q     <= pick ? bus.m1_addr  : bus.m0_addr;
            wdata_q    <= pick ? bus.m1_wdata : bus.m0_wdata;
            state      <= ISSUE;
          end
        end
        ISSUE: state <= (we_q || misaligned) ? IDLE : RESP;
        RESP: begin
          // Keep the returned word so the requester's rdata holds afterwards.
          if (win) rdata1_q <= bus.mem_out;
          else     rdata0_q <= bus.mem_out;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign issue     = (state == ISSUE);
  assign resp      = (state == RESP);
  assign dbg_state = state;

  assign bus.m0_gnt = issue && !win;
  assign bus.m1_gnt = issue &&  win;

`ifdef MEM_DATA_ARBITER_ALIGN_CHECK_EN
  assign bus.m0_err = issue && !win && misaligned;
  assign bus.m1_err = issue &&  win && misaligned;
`else
  assign bus.m0_err = 1'b0;
  assign bus.m1_err = 1'b0;
`endif

  assign bus.mem_write_en      = issue &&  we_q && !misaligned;
  assign bus.mem_read_en       = issue && !we_q && !misaligned;
  assign bus.mem_write_address = addr_q;
  assign bus.mem_read_address  = addr_q;
  assign bus.mem_data          = wdata_q;

  // Memory latched the word on the negedge of ISSUE; it is live through RESP.
  assign bus.m0_rvalid = resp && !win;
  assign bus.m1_rvalid = resp &&  win;
  assign bus.m0_rdata  = (resp && !win) ? bus.mem_out : rdata0_q;
  assign bus.m1_rdata  = (resp &&  win) ? bus.mem_out : rdata1_q;

endmodule

// File: tb/tb_mem_data_arbiter.sv
// Self-checking bench for mem_data_arbiter: directed scenarios plus random
// transactions against a transaction-level round-robin/memory model.
module tb_mem_data_arbiter;
  localparam int XL = 32;
  localparam int AL = 32;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  mem_data_arbiter_if #(.XLEN(XL), .ADDRESSLEN(AL)) bus();

  mem_data_arbiter #(.XLEN(XL), .ADDRESSLEN(AL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model ----------------
  logic [XL-1:0] mem [16];
  logic [XL-1:0] ref_mem [16];

  function automatic logic [XL-1:0] init_word(input int i);
    if (i == 2) return 32'hDEADBEEF;
    return 32'h5A00_0000 ^ (i * 32'h0103_0507);
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (bus.mem_write_en) mem[bus.mem_write_address[5:2]] = bus.mem_data;
    end
  end

  always @(negedge clk)
    if (bus.mem_read_en) bus.mem_out <= mem[bus.mem_read_address[5:2]];

  // ---------------- observation helpers ----------------
  logic [1:0]    gnt_w, rvalid_w, err_w;
  logic [XL-1:0] rdata_w [2];
  assign gnt_w      = {bus.m1_gnt, bus.m0_gnt};
  assign rvalid_w   = {bus.m1_rvalid, bus.m0_rvalid};
  assign err_w      = {bus.m1_err, bus.m0_err};
  assign rdata_w[0] = bus.m0_rdata;
  assign rdata_w[1] = bus.m1_rdata;

  // ---------------- scoreboard state ----------------
  int            assert_cnt = 0;
  int            fail_cnt   = 0;
  int            prev_winner;
  logic [XL-1:0] last_rdata [2];
  logic [XL-1:0] exp_q [$];

  function automatic logic is_misaligned(input logic [AL-1:0] a);
`ifdef MEM_DATA_ARBITER_ALIGN_CHECK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  task automatic drop_req(input int k);
    if (k == 0) bus.m0_req = 1'b0;
    else        bus.m1_req = 1'b0;
  endtask

  // One round: each enabled requester issues one access, held until gnt.
  task automatic run_txn(input logic v0, input logic we0, input logic [AL-1:0] a0,
                         input logic [XL-1:0] d0, input logic v1, input logic we1,
                         input logic [AL-1:0] a1, input logic [XL-1:0] d1, input string tag);
    logic          v [2];
    logic          we [2];
    logic [AL-1:0] a [2];
    logic [XL-1:0] d [2];
    logic          mis [2];
    int            eg [2];
    int            erv [2];
    logic [XL-1:0] edata [2];
    int            order [2];
    int            n;
    int            t;
    logic          ewen, eren, eg_now;
    logic [AL-1:0] eaddr;
    logic [XL-1:0] edat;
    v[0] = v0; we[0] = we0; a[0] = a0; d[0] = d0;
    v[1] = v1; we[1] = we1; a[1] = a1; d[1] = d1;
    for (int k = 0; k < 2; k++) begin
      mis[k] = v[k] && is_misaligned(a[k]);
      eg[k] = -1; erv[k] = -1; edata[k] = '0;
    end
    if (v0 && v1) begin
      order[0] = (prev_winner == 1) ? 0 : 1;
      order[1] = 1 - order[0];
      n = 2;
    end else begin
      order[0] = v1 ? 1 : 0;
      order[1] = 0;
      n = 1;
    end
    // Grant latency: 1 cycle; writes/errors take 2 cycles, reads 3.
    t = 1;
    for (int j = 0; j < n; j++) begin
      int k;
      k = order[j];
      eg[k] = t;
      if (!mis[k]) begin
        if (we[k]) ref_mem[a[k][5:2]] = d[k];
        else begin
          edata[k] = ref_mem[a[k][5:2]];
          exp_q.push_back(edata[k]);
          erv[k] = t + 1;
        end
      end
      t = t + ((we[k] || mis[k]) ? 2 : 3);
      prev_winner = k;
    end

    @(posedge clk); #1;
    bus.m0_req = v0; bus.m0_we = we0; bus.m0_addr = a0; bus.m0_wdata = d0;
    bus.m1_req = v1; bus.m1_we = we1; bus.m1_addr = a1; bus.m1_wdata = d1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      ewen = 1'b0; eren = 1'b0; eaddr = '0; edat = '0;
      for (int k = 0; k < 2; k++) begin
        eg_now = (c == eg[k]);
        assert_cnt++;
        if (gnt_w[k] !== eg_now) begin
          fail_cnt++;
          $display("FAIL %s gnt%0d c=%0d got %b want %b", tag, k, c, gnt_w[k], eg_now);
        end
        assert_cnt++;
        if (err_w[k] !== (eg_now && mis[k])) begin
          fail_cnt++;
          $display("FAIL %s err%0d c=%0d got %b want %b", tag, k, c, err_w[k], eg_now && mis[k]);
        end
        assert_cnt++;
        if (rvalid_w[k] !== (c == erv[k])) begin
          fail_cnt++;
          $display("FAIL %s rvalid%0d c=%0d got %b want %b", tag, k, c, rvalid_w[k], c == erv[k]);
        end
        if (c == erv[k]) begin
          edata[k] = exp_q.pop_front();
          last_rdata[k] = edata[k];
        end
        assert_cnt++;
        if (rdata_w[k] !== last_rdata[k]) begin
          fail_cnt++;
          $display("FAIL %s rdata%0d c=%0d got %h want %h", tag, k, c, rdata_w[k], last_rdata[k]);
        end
        if (eg_now && !mis[k]) begin
          ewen = we[k]; eren = !we[k]; eaddr = a[k]; edat = d[k];
        end
        if (eg_now) drop_req(k);
      end
      assert_cnt++;
      if (bus.mem_write_en !== ewen || bus.mem_read_en !== eren) begin
        fail_cnt++;
        $display("FAIL %s mem_en c=%0d got w%b r%b want w%b r%b", tag, c,
                 bus.mem_write_en, bus.mem_read_en, ewen, eren);
      end
      if (ewen) begin
        assert_cnt++;
        if (bus.mem_write_address !== eaddr || bus.mem_data !== edat) begin
          fail_cnt++;
          $display("FAIL %s mem_wr c=%0d got %h/%h want %h/%h", tag, c,
                   bus.mem_write_address, bus.mem_data, eaddr, edat);
        end
      end
      if (eren) begin
        assert_cnt++;
        if (bus.mem_read_address !== eaddr) begin
          fail_cnt++;
          $display("FAIL %s mem_rd_addr c=%0d got %h want %h", tag, c, bus.mem_read_address, eaddr);
        end
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    prev_winner = 1;
    last_rdata[0] = '0; last_rdata[1] = '0;
    repeat (3) @(negedge clk);
    assert_cnt++;
    if ({gnt_w, rvalid_w, err_w, bus.mem_write_en, bus.mem_read_en} !== 8'b0) begin
      fail_cnt++;
      $display("FAIL reset_ctrl got %b want 0", {gnt_w, rvalid_w, err_w, bus.mem_write_en, bus.mem_read_en});
    end
    assert_cnt++;
    if (rdata_w[0] !== '0 || rdata_w[1] !== '0) begin
      fail_cnt++;
      $display("FAIL reset_rdata got %h %h want 0", rdata_w[0], rdata_w[1]);
    end
    assert_cnt++;
    if (bus.mem_write_address !== '0 || bus.mem_read_address !== '0 || bus.mem_data !== '0) begin
      fail_cnt++;
      $display("FAIL reset_mem_bus got %h %h %h want 0", bus.mem_write_address,
               bus.mem_read_address, bus.mem_data);
    end
    assert_cnt++;
    if (dbg_state !== 2'd0) begin
      fail_cnt++;
      $display("FAIL reset_state got %0d want 0", dbg_state);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_tie_after_reset();
    run_txn(1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b1, 32'h30, 32'h0BAD_F00D, "tie_rst");
  endtask

  task automatic test_read_basic();
    run_txn(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, "rd_deadbeef");
  endtask

  task automatic test_write_read();
    run_txn(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h10, 32'h1234_5678, "m1_wr");
    run_txn(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, "m1_rd");
  endtask

  task automatic test_back_to_back();
    int exp_k;
    int grants;
    int k;
    exp_k = (prev_winner == 1) ? 0 : 1;
    grants = 0;
    @(posedge clk); #1;
    bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 32'h20; bus.m0_wdata = 32'hAAAA_0001;
    bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 32'h24; bus.m1_wdata = 32'hBBBB_0002;
    for (int c = 1; c <= 20 && grants < 6; c++) begin
      @(posedge clk); #1;
      assert_cnt++;
      if (gnt_w === 2'b11) begin
        fail_cnt++;
        $display("FAIL b2b_double_gnt c=%0d", c);
      end
      if (gnt_w !== 2'b00) begin
        k = gnt_w[1] ? 1 : 0;
        grants++;
        assert_cnt++;
        if (k != exp_k || c != 2 * grants - 1) begin
          fail_cnt++;
          $display("FAIL b2b_order c=%0d got m%0d want m%0d at c=%0d", c, k, exp_k, 2 * grants - 1);
        end
        assert_cnt++;
        if (bus.mem_write_en !== 1'b1) begin
          fail_cnt++;
          $display("FAIL b2b_wen c=%0d got %b want 1", c, bus.mem_write_en);
        end
        ref_mem[k == 0 ? 8 : 9] = (k == 0) ? 32'hAAAA_0001 : 32'hBBBB_0002;
        prev_winner = k;
        exp_k = 1 - k;
        if (grants == 6) begin
          bus.m0_req = 0; bus.m1_req = 0;
        end
      end
    end
    assert_cnt++;
    if (grants != 6) begin
      fail_cnt++;
      $display("FAIL b2b_timeout got %0d grants want 6", grants);
    end
    bus.m0_req = 0; bus.m1_req = 0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_align();
    logic [XL-1:0] old_w1;
    logic [XL-1:0] want;
    old_w1 = ref_mem[1];
    run_txn(1'b1, 1'b1, 32'h6, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 32'h0, "align_wr");
`ifdef MEM_DATA_ARBITER_ALIGN_CHECK_EN
    want = old_w1;
`else
    want = 32'hCAFE_F00D;
`endif
    assert_cnt++;
    if (mem[1] !== want) begin
      fail_cnt++;
      $display("FAIL align_mem_word1 got %h want %h", mem[1], want);
    end
  endtask

  task automatic test_random();
    logic          v0, v1;
    logic [AL-1:0] a0, a1;
    int            lo;
    for (int it = 0; it < 40; it++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int k = 0; k < 2; k++) begin
`ifdef MEM_DATA_ARBITER_ALIGN_CHECK_EN
        lo = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
`else
        lo = $urandom_range(0, 3);
`endif
        if (k == 0) a0 = AL'($urandom_range(0, 15) * 4 + lo);
        else        a1 = AL'($urandom_range(0, 15) * 4 + lo);
      end
      run_txn(v0, 1'($urandom_range(0, 1)), a0, $urandom,
              v1, 1'($urandom_range(0, 1)), a1, $urandom, "random");
    end
  endtask

  task automatic test_reset_abort();
    @(posedge clk); #1;
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'hC;
    @(posedge clk); #1;
    bus.m0_req = 0;
    @(posedge clk); #1;
    assert_cnt++;
    if (bus.m0_rvalid !== 1'b1) begin
      fail_cnt++;
      $display("FAIL abort_pre_rvalid got %b want 1", bus.m0_rvalid);
    end
    rst_n = 1'b0;
    #1;
    assert_cnt++;
    if (bus.m0_rvalid !== 1'b0 || bus.mem_read_en !== 1'b0 || bus.m0_rdata !== '0) begin
      fail_cnt++;
      $display("FAIL abort_in_reset got rv%b ren%b rdata %h want 0", bus.m0_rvalid,
               bus.mem_read_en, bus.m0_rdata);
    end
    prev_winner = 1;
    last_rdata[0] = '0; last_rdata[1] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      assert_cnt++;
      if ({gnt_w, rvalid_w, err_w, bus.mem_write_en, bus.mem_read_en} !== 8'b0) begin
        fail_cnt++;
        $display("FAIL abort_quiet c=%0d got %b want 0", c,
                 {gnt_w, rvalid_w, err_w, bus.mem_write_en, bus.mem_read_en});
      end
    end
  endtask

  task automatic test_memory_image();
    for (int i = 0; i < 16; i++) begin
      assert_cnt++;
      if (mem[i] !== ref_mem[i]) begin
        fail_cnt++;
        $display("FAIL mem_image[%0d] got %h want %h", i, mem[i], ref_mem[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tie_after_reset();
    test_read_basic();
    test_write_read();
    test_back_to_back();
    test_align();
    test_random();
    test_reset_abort();
    test_tie_after_reset();
    test_memory_image();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end
endmodule

// File: doc/mem_data_arbiter.md
MEM_DATA_ARBITER -- requirements
Module: mem_data_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data word width.
REQ-002 SHALL have parameter ADDRESSLEN, default 32, byte-address width.
REQ-003 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports m0_req / m1_req  input  1  access request, requester 0 = load/store unit, 1 = debug/DMA.
REQ-006 SHALL have ports m0_we / m1_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports m0_addr / m1_addr  input  ADDRESSLEN  byte address.
REQ-008 SHALL have ports m0_wdata / m1_wdata  input  XLEN  write data.
REQ-009 SHALL have ports m0_gnt / m1_gnt  output  1  one-cycle grant pulse; access issued this cycle.
REQ-010 SHALL have ports m0_rvalid / m1_rvalid  output  1  one-cycle read-data-valid pulse.
REQ-011 SHALL have ports m0_rdata / m1_rdata  output  XLEN  read data, meaningful only with rvalid.
REQ-012 SHALL have ports m0_err / m1_err  output  1  one-cycle misalignment error pulse.
REQ-013 SHALL have ports mem_write_address, mem_read_address  output  ADDRESSLEN  memory addresses.
REQ-014 SHALL have ports mem_data  output  XLEN; mem_write_en, mem_read_en  output  1; mem_out  input  XLEN  data memory port (memory latches reads on negedge clk).

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-016 IDLE: if any req, SHALL select winner, register its we/addr/wdata, and go to ISSUE next cycle; else stay IDLE.
REQ-017 Single request SHALL win; simultaneous requests SHALL go to requester not granted last (round-robin via last_grant bit).
REQ-018 ISSUE: SHALL assert winner's gnt for exactly one cycle and drive mem addresses/data from registered values.
REQ-019 ISSUE: SHALL assert mem_write_en (write) or mem_read_en (read) for exactly that one cycle; never both.
REQ-020 ISSUE write SHALL go to IDLE next cycle (2-cycle access); ISSUE read SHALL go to RESP.
REQ-021 RESP: SHALL drive winner's rdata = mem_out and rvalid = 1 for one cycle, then go to IDLE (3-cycle read).
REQ-022 Non-winner rvalid/gnt/err SHALL stay 0; rdata of non-winner SHALL hold last value.
REQ-023 Requester SHALL hold req and operands until gnt; req dropped after capture SHALL NOT abort the access.
REQ-024 last_grant SHALL update on every ISSUE entry, including error-terminated accesses.
REQ-025 mem_write_address and mem_read_address SHALL both carry the captured address; memory enables qualify use.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, all gnt/rvalid/err/mem_write_en/mem_read_en = 0, rdata = 0, mem addresses/data = 0, last_grant = 1.
REQ-027 Reset during ISSUE or RESP SHALL abort the access; no rvalid SHALL follow reset release.
REQ-028 First tie after reset SHALL grant requester 0.

Configuration
REQ-029 Macro MEM_DATA_ARBITER_ALIGN_CHECK_EN SHALL control alignment checking.
REQ-030 With macro: captured addr[1:0] != 0 SHALL pulse winner's gnt and err in ISSUE, assert no mem enable, and return to IDLE.
REQ-031 Without macro: m0_err/m1_err SHALL be constant 0; addr[1:0] ignored, access proceeds.

Verification
REQ-032 Reset, then m0 read addr 0x8 with mem word 2 = 0xDEADBEEF -> m0_gnt at cycle 2, m0_rvalid at cycle 3 with m0_rdata 0xDEADBEEF.
REQ-033 m1 write addr 0x10 data 0x12345678 -> mem_write_en one cycle with mem_data 0x12345678; m1 read 0x10 -> rdata 0x12345678.
REQ-034 Both req held continuously after reset -> grants alternate m0, m1, m0, m1; no cycle with two gnt.
REQ-035 rst_n low during RESP of m0 read -> rvalid, mem_read_en 0 immediately; after release, idle with no req -> no outputs asserted.
REQ-036 Macro defined, m0 write addr 0x6 -> m0_gnt and m0_err pulse together, mem_write_en stays 0, memory unchanged; macro undefined -> write lands at word 1.
